// File: rtl/seq_rem_pkg.sv
// Shared types and defaults for the sequential sign-magnitude remainder unit.
package seq_rem_pkg;

  localparam int SEQ_REM_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rem_step.sv
// One restoring-division step. The partial remainder is shifted left with the
// next dividend bit appended, and |B| is subtracted on a trial basis. The
// difference is kept only when it is non-negative.
module rem_step #(
  parameter int M = 7
) (
  input  logic [M-1:0] rem_i,
  input  logic         bit_i,
  input  logic [M-1:0] div_i,
  output logic [M-1:0] rem_o,
  output logic         q_o
);

  logic [M:0] shifted;

  // Trial subtract. Both candidate results are smaller than the divisor, so they fit in M bits.
  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= {1'b0, div_i});
    rem_o   = q_o ? M'(shifted - {1'b0, div_i}) : shifted[M-1:0];
  end

endmodule

// File: rtl/seq_rem.sv
// Sequential sign-magnitude remainder, one restoring step per clock, MSB first.
// Optional quotient output: define SEQ_REM_QUOT_EN to add the Quot port.
//
// Handshake: start is sampled only in IDLE. busy is high for the M CALC
// cycles, and done pulses for one cycle in DONE. Res and the flags become
// valid with done and hold until the next result is written. A start seen
// in CALC or DONE is dropped and is not remembered.
module seq_rem
  import seq_rem_pkg::*;
#(
  parameter int W = SEQ_REM_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] NumA,
  input  logic [W-1:0] NumB,
  output logic         busy,
  output logic         done,
  output logic [W:0]   Res,
  output logic         negF,
  output logic         zerF,
  output logic         DZF,
`ifdef SEQ_REM_QUOT_EN
  output logic [W-1:0] Quot,
`endif
  output state_e       dbg_state
);

  localparam int M  = W - 1;
  localparam int CW = $clog2(M + 1);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [M-1:0]    dvd_q, dvd_d;      // dividend bits shift out, quotient bits shift in
  logic [M-1:0]    div_q, div_d;
  logic [M-1:0]    rem_q, rem_d;
  logic            sa_q, sa_d;
  logic            res_sign_q, res_sign_d;
  logic [M-1:0]    res_mag_q, res_mag_d;
  logic            zer_q, zer_d;
  logic            dz_q, dz_d;
  logic [M-1:0]    rem_nxt;
  logic            q_bit;
  logic [M-1:0]    quot_mag;

`ifdef SEQ_REM_QUOT_EN
  logic            sb_q, sb_d;
  logic [W-1:0]    quot_q, quot_d;
`else
  logic            unused_sign_b;
  assign unused_sign_b = NumB[W-1];
`endif

  rem_step #(.M(M)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[M-1]),
    .div_i (div_q),
    .rem_o (rem_nxt),
    .q_o   (q_bit)
  );

  assign quot_mag = {dvd_q[M-2:0], q_bit};

  // Next-state, operand capture, iteration and result capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    div_d      = div_q;
    rem_d      = rem_q;
    sa_d       = sa_q;
    res_sign_d = res_sign_q;
    res_mag_d  = res_mag_q;
    zer_d      = zer_q;
    dz_d       = dz_q;
`ifdef SEQ_REM_QUOT_EN
    sb_d       = sb_q;
    quot_d     = quot_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d  = NumA[W-1];
          dvd_d = NumA[M-1:0];
          div_d = NumB[M-1:0];
          rem_d = '0;
          cnt_d = '0;
`ifdef SEQ_REM_QUOT_EN
          sb_d  = NumB[W-1];
`endif
          if (NumB[M-1:0] == '0) begin
            // Division by zero: the result is ready immediately.
            state_d    = DONE;
            res_sign_d = 1'b0;
            res_mag_d  = '0;
            zer_d      = 1'b0;
            dz_d       = 1'b1;
`ifdef SEQ_REM_QUOT_EN
            quot_d     = '0;
`endif
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_nxt;
        dvd_d = quot_mag;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d    = DONE;
          res_mag_d  = rem_nxt;
          res_sign_d = sa_q && (rem_nxt != '0);
          zer_d      = (rem_nxt == '0);
          dz_d       = 1'b0;
`ifdef SEQ_REM_QUOT_EN
          quot_d     = {(sa_q ^ sb_q) && (quot_mag != '0), quot_mag};
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      div_q      <= '0;
      rem_q      <= '0;
      sa_q       <= 1'b0;
      res_sign_q <= 1'b0;
      res_mag_q  <= '0;
      zer_q      <= 1'b0;
      dz_q       <= 1'b0;
`ifdef SEQ_REM_QUOT_EN
      sb_q       <= 1'b0;
      quot_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      sa_q       <= sa_d;
      res_sign_q <= res_sign_d;
      res_mag_q  <= res_mag_d;
      zer_q      <= zer_d;
      dz_q       <= dz_d;
`ifdef SEQ_REM_QUOT_EN
      sb_q       <= sb_d;
      quot_q     <= quot_d;
`endif
    end
  end

  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign Res       = {res_sign_q, 1'b0, res_mag_q};
  assign negF      = res_sign_q;
  assign zerF      = zer_q;
  assign DZF       = dz_q;
  assign dbg_state = state_q;
`ifdef SEQ_REM_QUOT_EN
  assign Quot      = quot_q;
`endif

endmodule

// File: tb/tb_seq_rem.sv
// Bench for seq_rem at W=4, covering the quotient output when SEQ_REM_QUOT_EN is defined.
module tb_seq_rem;
  import seq_rem_pkg::*;

  localparam int W = 4;
  localparam int M = W - 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] NumA  = '0;
  logic [W-1:0] NumB  = '0;
  logic         busy, done, negF, zerF, DZF;
  logic [W:0]   Res;
  state_e       dbg_state;
`ifdef SEQ_REM_QUOT_EN
  logic [W-1:0] Quot;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [W:0]   res;
    logic         zer;
    logic         dz;
    logic [W-1:0] quot;
    logic [7:0]   lat;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  exp_t exp_q[$];

  seq_rem #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .NumA      (NumA),
    .NumB      (NumB),
    .busy      (busy),
    .done      (done),
    .Res       (Res),
    .negF      (negF),
    .zerF      (zerF),
    .DZF       (DZF),
`ifdef SEQ_REM_QUOT_EN
    .Quot      (Quot),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: signed remainder and quotient computed directly with integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ma, mb, rm, qm;
    e  = '0;
    ma = int'(a[W-2:0]);
    mb = int'(b[W-2:0]);
    if (mb == 0) begin
      e.dz  = 1'b1;
      e.lat = 8'd1;
    end else begin
      rm = ma % mb;
      qm = ma / mb;
      e.res[W-1:0]  = W'(rm);
      e.res[W]      = a[W-1] && (rm != 0);
      e.zer         = (rm == 0);
      e.quot[W-2:0] = (W-1)'(qm);
      e.quot[W-1]   = (a[W-1] ^ b[W-1]) && (qm != 0);
      e.lat         = 8'(M + 1);
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  // Issues one operation. If hold is set, start stays high until done.
  // If scramble is set, the operand inputs are randomised after acceptance.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit hold, input bit scramble);
    exp_t e;
    int   lat;
    bit   seen;
    @(negedge clk);
    NumA  = a;
    NumB  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    if (scramble) begin
      NumA = W'($urandom_range(0, 15));
      NumB = W'($urandom_range(0, 15));
    end
    e    = exp_q.pop_front();
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 3 * M + 6 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) check("busy_first_cycle", busy, e.lat > 1);
      if (done) begin
        seen = 1'b1;
        lat  = n;
      end else if (scramble) begin
        NumA = W'($urandom_range(0, 15));
        NumB = W'($urandom_range(0, 15));
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1'b1);
    check("latency", lat, e.lat);
    check("res", Res, e.res);
    check("negF", negF, e.res[W]);
    check("zerF", zerF, e.zer);
    check("DZF", DZF, e.dz);
    check("busy_in_done", busy, 1'b0);
`ifdef SEQ_REM_QUOT_EN
    check("quot", Quot, e.quot);
`endif
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("res_hold", Res, e.res);
    check("dz_hold", DZF, e.dz);
  endtask

  // ---------------- stimulus ----------------
  vec_t vt[8];

  initial begin
    int extra;
    logic [W-1:0] ra, rb;

    vt[0] = '{a:4'b1101, b:4'b0011, e:'{res:5'b10010, zer:1'b0, dz:1'b0, quot:4'b1001, lat:8'd4}};
    vt[1] = '{a:4'b0110, b:4'b1011, e:'{res:5'b00000, zer:1'b1, dz:1'b0, quot:4'b1010, lat:8'd4}};
    vt[2] = '{a:4'b0101, b:4'b1000, e:'{res:5'b00000, zer:1'b0, dz:1'b1, quot:4'b0000, lat:8'd1}};
    vt[3] = '{a:4'b1000, b:4'b0011, e:'{res:5'b00000, zer:1'b1, dz:1'b0, quot:4'b0000, lat:8'd4}};
    vt[4] = '{a:4'b1111, b:4'b0010, e:'{res:5'b10001, zer:1'b0, dz:1'b0, quot:4'b1011, lat:8'd4}};
    vt[5] = '{a:4'b0111, b:4'b1111, e:'{res:5'b00000, zer:1'b1, dz:1'b0, quot:4'b1001, lat:8'd4}};
    vt[6] = '{a:4'b0010, b:4'b0101, e:'{res:5'b00010, zer:1'b0, dz:1'b0, quot:4'b0000, lat:8'd4}};
    vt[7] = '{a:4'b1110, b:4'b0100, e:'{res:5'b10010, zer:1'b0, dz:1'b0, quot:4'b1001, lat:8'd4}};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_res", Res, '0);
    check("rst_flags", {negF, zerF, DZF}, 3'b000);
    check("rst_state", dbg_state, IDLE);
`ifdef SEQ_REM_QUOT_EN
    check("rst_quot", Quot, '0);
`endif
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vt[i].e);
      do_op(vt[i].a, vt[i].b, 1'b0, 1'b0);
    end

    // start held high through an operation, with operands changed mid-CALC
    exp_q.push_back('{res:5'b00001, zer:1'b0, dz:1'b0, quot:4'b0010, lat:8'd4});
    do_op(4'b0111, 4'b0011, 1'b1, 1'b1);
    extra = 0;
    repeat (6) @(negedge clk) if (done) extra++;
    check("held_start_single_done", extra, 0);

    // Reset during CALC cycle 2, after a result with a nonzero sign is present
    exp_q.push_back(vt[0].e);
    do_op(vt[0].a, vt[0].b, 1'b0, 1'b0);
    @(negedge clk);
    NumA  = 4'b0111;
    NumB  = 4'b0010;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_res", Res, '0);
    check("midrst_flags", {negF, zerF, DZF}, 3'b000);
    check("midrst_busy_done", {busy, done}, 2'b00);
    check("midrst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (8) @(negedge clk) if (done) extra++;
    check("midrst_no_done", extra, 0);
    exp_q.push_back(model(4'b1011, 4'b0010));
    do_op(4'b1011, 4'b0010, 1'b0, 1'b0);

    // Exhaustive sweep with random start holding and operand scrambling
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        exp_q.push_back(model(W'(a), W'(b)));
        do_op(W'(a), W'(b), bit'($urandom_range(0, 1)), 1'b1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    // Random operand pairs
    repeat (60) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      exp_q.push_back(model(ra, rb));
      do_op(ra, rb, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_rem.md
SEQ_REM -- requirements
Module: seq_rem

Interface
REQ-001 Parameter W, default 8, operand width in sign-magnitude; bit W-1 is the sign, bits W-2:0 are the magnitude (M = W-1 bits); legal W >= 3.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 NumA  input  W  dividend, sign-magnitude.
REQ-006 NumB  input  W  divisor, sign-magnitude.
REQ-007 busy  output  1  high in CALC.
REQ-008 done  output  1  one-cycle pulse in DONE; marks Res and flags as valid.
REQ-009 Res  output  W+1  remainder; bit W is the sign, bits W-1:0 are the magnitude, zero-extended from M bits.
REQ-010 negF  output  1  equals Res[W].
REQ-011 zerF  output  1  remainder magnitude is 0 and DZF is 0.
REQ-012 DZF  output  1  divisor magnitude was 0.

Function
REQ-013 States: IDLE, CALC, DONE. IDLE->CALC on start=1 when |NumB|!=0; IDLE->DONE on start=1 when |NumB|==0; CALC->DONE after exactly M iteration cycles; DONE->IDLE unconditionally.
REQ-014 On the accepting edge, NumA and NumB are registered; input changes after that edge have no effect on the operation.
REQ-015 CALC runs one restoring-division step per cycle, MSB first: shift partial remainder, trial subtract |B|, keep if non-negative.
REQ-016 Latency: done is high M+1 edges after the accepting edge, or 1 edge after it when dividing by zero.
REQ-017 Remainder magnitude = |A| mod |B|; remainder sign = sign(A); sign is forced to 0 when the magnitude is 0 (no negative zero).
REQ-018 Divide by zero: Res=0, DZF=1, zerF=0, negF=0.
REQ-019 Res, negF, zerF and DZF update on the edge entering DONE, then hold until the next accepted start.
REQ-020 start=1 while busy or in DONE is ignored; it is neither queued nor a restart.
REQ-021 A magnitude-0 dividend with a non-zero divisor gives Res=0, zerF=1, negF=0, DZF=0.
REQ-022 A negative-zero input (sign=1, magnitude=0) is treated as +0.

Reset
REQ-023 rst_n low forces state IDLE and busy, done, Res, negF, zerF, DZF all to 0, immediately and asynchronously.
REQ-024 Reset during CALC abandons the operation; no done pulse is produced for it.

Configuration
REQ-025 Macro SEQ_REM_QUOT_EN, when defined, adds output Quot (W bits, sign-magnitude): magnitude = |A| / |B|, sign = sign(A) XOR sign(B), forced to 0 for a zero magnitude; Quot=0 on divide by zero; reset value 0; updated and held like Res.
REQ-026 Without SEQ_REM_QUOT_EN there is no Quot port, no quotient register, and all other behaviour is identical.

Structure
REQ-027 Package seq_rem_pkg holds the state enum (IDLE, CALC, DONE) and the constant SEQ_REM_W_DEF=8.
REQ-028 Sub-module rem_step is combinational: one restoring step taking the partial remainder, the next dividend bit and the divisor, and returning the new partial remainder and the quotient bit; it is instantiated once.
REQ-029 The iteration counter is ceil(log2(M+1)) bits wide.

Verification (W=4, M=3)
REQ-030 NumA=4'b1101 (-5), NumB=4'b0011 (+3), start -> done 4 edges later; Res=5'b10010 (-2), negF=1, zerF=0, DZF=0.
REQ-031 NumA=4'b0110 (+6), NumB=4'b1011 (-3) -> Res=0, zerF=1, negF=0; with SEQ_REM_QUOT_EN, Quot=4'b1010.
REQ-032 NumA=4'b0101, NumB=4'b1000 (-0) -> done 1 edge later; DZF=1, Res=0.
REQ-033 start held high through an operation, with a second operand pair applied mid-CALC -> exactly one done; result matches the first operand pair.
REQ-034 rst_n pulsed low during CALC cycle 2 -> outputs 0 at once, no done; a new start then completes normally.
REQ-035 Exhaustive sweep over all 4-bit pairs compared against a reference model, including latency checks.
